wb_stage: RTL
=============

# wb_stage

Writeback end of the pipeline: consumes the write requests produced by the memory-access stage (GPR write and HI/LO write), registers them in the MEM/WB pipeline latch, and commits them to the 32×32 general register file and the HI/LO pair. It owns the architectural register state. It serves two combinational GPR read ports and the HI/LO read values, with same-cycle bypass of the pending writeback, to the decode and execute stages.

## Interface

Parameters:
- None. Widths are fixed: 32-bit data, 5-bit register address.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stall_i  in  1  hold MEM/WB latch contents
- flush_i  in  1  load a bubble into MEM/WB latch; priority over stall_i
- wreg_i  in  1  GPR write enable from memory-access stage
- waddr_i  in  5  GPR write address
- wdata_i  in  32  GPR write data
- whilo_i  in  1  HI/LO write enable
- hi_i  in  32  HI write data
- lo_i  in  32  LO write data
- re1_i  in  1  read port 1 enable
- raddr1_i  in  5  read port 1 address
- rdata1_o  out  32  read port 1 data (combinational)
- re2_i  in  1  read port 2 enable
- raddr2_i  in  5  read port 2 address
- rdata2_o  out  32  read port 2 data (combinational)
- hi_o  out  32  current HI, bypassed (combinational)
- lo_o  out  32  current LO, bypassed (combinational)
- wb_wreg_o  out  1  latched GPR write enable (forwarding source)
- wb_waddr_o  out  5  latched GPR write address
- wb_wdata_o  out  32  latched GPR write data

## Operation

- MEM/WB latch fields: wreg, waddr, wdata, whilo, hi, lo.
- Latch update at each edge, priority order:
  - rst low: all fields 0.
  - flush_i: all fields 0 (bubble).
  - stall_i: hold.
  - Otherwise: load the *_i inputs.
- Commit, every edge while rst is high:
  - If latch wreg=1 and waddr≠0: regs[waddr] ← wdata.
  - If latch whilo=1: HI ← hi, LO ← lo.
  - Commit is not gated by stall_i. A held latch rewrites the same value, which is harmless.
- Reset: regs[0..31], HI and LO all 0, asynchronously.
- Read port n:
  - re=0 → 0.
  - raddr=0 → 0. Register 0 is hardwired to zero and never written.
  - re=1, raddr = latch waddr, latch wreg=1, waddr≠0 → latch wdata (bypass).
  - Otherwise → regs[raddr].
  - Both ports are independent. Both may hit the bypass together.
- HI/LO read: hi_o = latch whilo ? latch hi : HI; lo_o likewise.
- wb_* outputs drive the latch fields directly.

## Timing

- Request presented on the *_i inputs in cycle N is captured at the end of cycle N.
- Cycle N+1: the value appears on wb_* outputs and on any matching read port via the bypass.
- Cycle N+1 end: the value commits to the array. From cycle N+2 it is read from the array.
- Net effect: a read of the target register returns the new value from cycle N+1 onward, with no gap.
- Back-to-back writes to the same register in cycles N and N+1: the later write wins. The read in cycle N+2 returns the second value.
- Simultaneous GPR write and HI/LO write in the same request: both commit on the same edge.
- Reset mid-operation: rst low clears the latch, array and HI/LO immediately, with no clock needed. All outputs read 0 while rst is low. The first request after reset release is captured at the first rising edge with rst high.
- All outputs are 0 during reset, because reads return 0 from a zeroed array and an empty latch.

## Test plan

- Reset: pulse rst low mid-run after writing r7=0x1234_5678. Then read r7, hi_o, lo_o and wb_* → all 0, with no clock edge required.
- Write and read: drive wreg_i=1, waddr_i=5, wdata_i=0xDEAD_BEEF for 1 cycle. Read r5 on port 1 in the next cycle → 0xDEAD_BEEF via bypass. Read again 2 cycles later → 0xDEAD_BEEF from the array.
- Zero register: write r0=0xFFFF_FFFF, then read r0 on both ports in the next 2 cycles → 0. Also, port 2 with re2_i=0 and raddr2_i=5 → 0.
- HI/LO: drive whilo_i=1, hi_i=0xAAAA_0001, lo_i=0x5555_0002. Next cycle hi_o/lo_o return those values via bypass. After a following bubble cycle they are unchanged from HI/LO.
- Stall and flush:
  - Latch a write r3=0x11, then assert stall_i with new input r3=0x22 → r3 reads 0x11 while stalled.
  - Assert flush_i together with stall_i → wb_wreg_o=0 next cycle, and r3 keeps 0x11.
- Back-to-back: write r9=1 then r9=2 on consecutive cycles → r9 reads 1, then 2, then stays 2.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if: bundle between the memory-access stage / register readers and
// the writeback stage.
//   master : drives write requests, pipeline control and read addresses;
//            receives read data, HI/LO and the latched writeback fields.
//   slave  : the writeback stage itself.
interface wb_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        whilo_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic [31:0] rdata1_o;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata2_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        wb_wreg_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  modport master (
    output stall_i, flush_i, wreg_i, waddr_i, wdata_i, whilo_i, hi_i, lo_i,
           re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, hi_o, lo_o, wb_wreg_o, wb_waddr_o, wb_wdata_o
  );

  modport slave (
    input  stall_i, flush_i, wreg_i, waddr_i, wdata_i, whilo_i, hi_i, lo_i,
           re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o, hi_o, lo_o, wb_wreg_o, wb_waddr_o, wb_wdata_o
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline latch plus the architectural GPR file (32x32)
// and HI/LO pair. Commits the latched request every edge and serves two
// combinational GPR read ports and HI/LO reads, bypassing the pending
// (latched, not yet committed) writeback so a write is visible from the
// cycle after it is presented.
// Ports:
//   clk  - pipeline clock, rising edge
//   rst  - asynchronous, active-low reset; clears latch, GPRs and HI/LO
//   bus  - wb_stage_if.slave: requests, stall/flush, read ports, wb_* fields
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   bus
);

  logic        wreg_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        whilo_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] regs [0:31];
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  // MEM/WB latch: flush beats stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.flush_i) begin
      wreg_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (!bus.stall_i) begin
      wreg_q  <= bus.wreg_i;
      waddr_q <= bus.waddr_i;
      wdata_q <= bus.wdata_i;
      whilo_q <= bus.whilo_i;
      hi_q    <= bus.hi_i;
      lo_q    <= bus.lo_i;
    end
  end

  // Commit is deliberately not gated by stall: a held latch just rewrites
  // the same value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      if (wreg_q && (waddr_q != 5'd0)) regs[waddr_q] <= wdata_q;
      if (whilo_q) begin
        hi_r <= hi_q;
        lo_r <= lo_q;
      end
    end
  end

  // raddr != 0 plus address equality already implies the latched waddr != 0.
  always_comb begin
    bus.rdata1_o = '0;
    if (bus.re1_i && (bus.raddr1_i != 5'd0)) begin
      if (wreg_q && (bus.raddr1_i == waddr_q)) bus.rdata1_o = wdata_q;
      else                                     bus.rdata1_o = regs[bus.raddr1_i];
    end
  end

  always_comb begin
    bus.rdata2_o = '0;
    if (bus.re2_i && (bus.raddr2_i != 5'd0)) begin
      if (wreg_q && (bus.raddr2_i == waddr_q)) bus.rdata2_o = wdata_q;
      else                                     bus.rdata2_o = regs[bus.raddr2_i];
    end
  end

  assign bus.hi_o       = whilo_q ? hi_q : hi_r;
  assign bus.lo_o       = whilo_q ? lo_q : lo_r;
  assign bus.wb_wreg_o  = wreg_q;
  assign bus.wb_waddr_o = waddr_q;
  assign bus.wb_wdata_o = wdata_q;

endmodule
